// File: rtl/fb_stream_sink.sv
// RGB555 stream-to-memory sink: aligns to frame start, groups pixels into fixed bursts
// and writes them linearly to an Avalon-MM-style master. Optional: FB_STREAM_SINK_DOUBLE_BUFFER_EN.
module fb_stream_sink #(
    parameter int pW              = 640,
    parameter int pH              = 480,
    parameter int pBURST          = 16,
    parameter int pBASE           = 0,
    parameter int pBASE1          = 640*480,
    parameter int pMEM_ADDR_WIDTH = 22
) (
    input  logic                         iFB_CLK,
    input  logic                         iFB_RESET,
    input  logic                         iFB_START,
    input  logic [14:0]                  iFB_DATA,
    input  logic                         iFB_DATAVALID,
    output logic                         oFB_READY,
    output logic [pMEM_ADDR_WIDTH-1:0]   oMEM_ADDRESS,
    output logic                         oMEM_WRITE,
    output logic [15:0]                  oMEM_WRITEDATA,
    output logic [$clog2(pBURST):0]      oMEM_BURSTCOUNT,
`ifdef FB_STREAM_SINK_DOUBLE_BUFFER_EN
    output logic                         oFRAME_SEL,
`endif
    input  logic                         iMEM_WAITREQUEST,
    output logic                         oFRAME_DONE,
    output logic                         oFRAME_ERR
);

    localparam int NPIX  = pW * pH;
    localparam int PIX_W = $clog2(NPIX);
    localparam int BW    = $clog2(pBURST);
    localparam int DEPTH = 2 * pBURST;
    localparam int PTR_W = BW + 1;
    localparam int CNT_W = BW + 2;
    localparam int AW    = pMEM_ADDR_WIDTH;

    if ((NPIX % pBURST) != 0) begin : g_bad_frame
        $error("fb_stream_sink: pW*pH must be a multiple of pBURST");
    end
    if ((pBURST < 2) || (pBURST > 128) || ((1 << BW) != pBURST)) begin : g_bad_burst
        $error("fb_stream_sink: pBURST must be a power of two in 2..128");
    end
    if ((pBASE < 0) || (pBASE1 < 0)) begin : g_bad_base
        $error("fb_stream_sink: base addresses must be non-negative");
    end

    typedef enum logic {S_SYNC, S_RUN}    in_state_t;
    typedef enum logic {B_IDLE, B_BURST}  bst_state_t;

    in_state_t             r_state, w_state_nxt;
    bst_state_t            r_bstate, w_bstate_nxt;

    logic [14:0]           r_buf [DEPTH];
    logic [PTR_W-1:0]      r_wp, r_rp;
    logic [CNT_W-1:0]      r_cnt;
    logic [PIX_W-1:0]      r_pix;
    logic [BW-1:0]         r_beat;
    logic [AW-1:0]         r_mem_addr;
    logic                  r_done, r_err;

    logic [AW-1:0]         r_tag_addr [2];
    logic [1:0]            r_tag_last;
    logic                  r_tag_head;
    logic [1:0]            r_tag_cnt;

    logic                  w_ready, w_store, w_unexp;
    logic [PIX_W-1:0]      w_pix_idx, w_pix_nxt, w_grp_first;
    logic [PTR_W-1:0]      w_rew, w_wr_ptr;
    logic                  w_grp_done, w_last, w_beat, w_burst_end, w_tag_wr;
    logic [AW-1:0]         w_base, w_tag_addr;

    // Ingest side: alignment, back-pressure and the index of the pixel being stored
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b1;
        w_store     = 1'b0;
        w_unexp     = 1'b0;
        w_pix_idx   = r_pix;
        case (r_state)
            S_SYNC: begin
                w_store   = iFB_DATAVALID & iFB_START;
                w_pix_idx = '0;
                if (w_store) w_state_nxt = S_RUN;
            end
            default: begin
                w_ready = (r_cnt < CNT_W'(DEPTH));
                w_store = iFB_DATAVALID & w_ready;
                w_unexp = w_store & iFB_START & (r_pix != '0);
                if (w_unexp) w_pix_idx = '0;
            end
        endcase
    end

    // Groups are aligned to the frame, so the partial-group fill level is the low bits of r_pix
    assign w_rew       = w_unexp ? PTR_W'(r_pix[BW-1:0]) : '0;
    assign w_wr_ptr    = r_wp - w_rew;
    assign w_last      = (w_pix_idx == PIX_W'(NPIX - 1));
    assign w_pix_nxt   = w_last ? '0 : w_pix_idx + PIX_W'(1);
    assign w_grp_done  = w_store & (w_pix_idx[BW-1:0] == BW'(pBURST - 1));
    assign w_grp_first = w_pix_idx & ~PIX_W'(pBURST - 1);
    assign w_tag_addr  = w_base + AW'(w_grp_first);
    assign w_tag_wr    = r_tag_head ^ r_tag_cnt[0];

    assign w_beat      = (r_bstate == B_BURST) & ~iMEM_WAITREQUEST;
    assign w_burst_end = w_beat & (r_beat == BW'(pBURST - 1));

    always_comb begin
        w_bstate_nxt = r_bstate;
        case (r_bstate)
            B_IDLE:  if (r_tag_cnt != 2'd0) w_bstate_nxt = B_BURST;
            default: if (w_burst_end)       w_bstate_nxt = B_IDLE;
        endcase
    end

    always_ff @(posedge iFB_CLK) begin
        if (iFB_RESET) begin
            r_state  <= S_SYNC;
            r_bstate <= B_IDLE;
        end else begin
            r_state  <= w_state_nxt;
            r_bstate <= w_bstate_nxt;
        end
    end

    always_ff @(posedge iFB_CLK) begin
        if (iFB_RESET) begin
            for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
            r_wp          <= '0;
            r_rp          <= '0;
            r_cnt         <= '0;
            r_pix         <= '0;
            r_beat        <= '0;
            r_mem_addr    <= '0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_tag_addr[0] <= '0;
            r_tag_addr[1] <= '0;
            r_tag_last    <= '0;
            r_tag_head    <= 1'b0;
            r_tag_cnt     <= '0;
        end else begin
            if (w_store) begin
                r_buf[w_wr_ptr] <= iFB_DATA;
                r_pix           <= w_pix_nxt;
            end
            r_wp   <= w_wr_ptr + PTR_W'(w_store);
            r_rp   <= r_rp + PTR_W'(w_beat);
            r_cnt  <= r_cnt - CNT_W'(w_rew) + CNT_W'(w_store) - CNT_W'(w_beat);
            r_err  <= w_unexp;
            r_done <= w_burst_end & r_tag_last[r_tag_head];

            if ((r_bstate == B_IDLE) && (w_bstate_nxt == B_BURST))
                r_mem_addr <= r_tag_addr[r_tag_head];
            if (w_beat)
                r_beat <= w_burst_end ? '0 : r_beat + BW'(1);

            // The tag pop coincides with the pop of the group's last word, so at most two tags exist
            if (w_grp_done) begin
                r_tag_addr[w_tag_wr] <= w_tag_addr;
                r_tag_last[w_tag_wr] <= w_last;
            end
            if (w_burst_end) r_tag_head <= ~r_tag_head;
            r_tag_cnt <= r_tag_cnt + 2'(w_grp_done) - 2'(w_burst_end);
        end
    end

`ifdef FB_STREAM_SINK_DOUBLE_BUFFER_EN
    logic       r_wsel, r_frame_sel;
    logic [1:0] r_tag_sel;

    assign w_base     = r_wsel ? AW'(pBASE1) : AW'(pBASE);
    assign oFRAME_SEL = r_frame_sel;

    // Write-side select flips when a frame's last group is tagged or a frame is aborted
    always_ff @(posedge iFB_CLK) begin
        if (iFB_RESET) begin
            r_wsel      <= 1'b0;
            r_frame_sel <= 1'b0;
            r_tag_sel   <= '0;
        end else begin
            if ((w_grp_done & w_last) | w_unexp) r_wsel <= ~r_wsel;
            if (w_grp_done) r_tag_sel[w_tag_wr] <= r_wsel;
            if (w_burst_end & r_tag_last[r_tag_head]) r_frame_sel <= r_tag_sel[r_tag_head];
        end
    end
`else
    assign w_base = AW'(pBASE);
`endif

    assign oFB_READY       = w_ready;
    assign oMEM_ADDRESS    = r_mem_addr;
    assign oMEM_WRITE      = (r_bstate == B_BURST);
    assign oMEM_WRITEDATA  = (r_bstate == B_BURST) ? {1'b0, r_buf[r_rp[PTR_W-1:0]]} : 16'h0000;
    assign oMEM_BURSTCOUNT = (BW + 1)'(pBURST);
    assign oFRAME_DONE     = r_done;
    assign oFRAME_ERR      = r_err;

endmodule
